// File: rtl/m3_run_sequencer.sv
// m3_run_sequencer: run-control FSM for one 3-phase motor channel.
// Owns run state, rotation direction, speed target/level and power level.
// Speed ramps one level per 100 Hz tick; each step is echoed as a one-cycle
// speedINCo/speedDECo pulse so the downstream speed calculator can follow it.
// Optional build macro: M3_REVERSE_DEADTIME_EN adds the DEAD state, which
// holds zero speed for DEAD_TICKS ticks before a direction flip.
//
// state     | code | meaning
// IDLE      | 0    | motor off, speed and power 0
// RAMP_UP   | 1    | stepping speed up toward target
// RUN       | 2    | speed equals target
// RAMP_DOWN | 3    | stepping down to target, or to 0 when stopping/reversing
// DEAD      | 4    | zero-speed hold before direction flip (option only)
module m3_run_sequencer #(
  parameter int SPEED_W        = 4,
  parameter int POWER_W        = 4,
  parameter int SPEED_MAX      = 15,
  parameter int POWER_MAX      = 15,
  parameter int POWER_MIN      = 1,
  parameter int POWER_START    = 4,
  parameter int SPEED_TGT_INIT = 8,
  parameter int DEAD_TICKS     = 10
) (
  input  logic               clkI,
  input  logic               rstI,
  input  logic               tick100hzI,
  input  logic               startI,
  input  logic               forceStopI,
  input  logic               invRotateI,
  input  logic               speedINCi,
  input  logic               speedDECi,
  input  logic               powerINCi,
  input  logic               powerDECi,
  output logic               workingO,
  output logic               dirO,
  output logic [SPEED_W-1:0] speedLvlO,
  output logic [SPEED_W-1:0] speedTgtO,
  output logic [POWER_W-1:0] powerLvlO,
  output logic               speedINCo,
  output logic               speedDECo,
  output logic [2:0]         stateO
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_DEAD      = 3'd4;

  localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] SPD_MIN   = SPEED_W'(1);
  localparam logic [SPEED_W-1:0] SPD_INIT  = SPEED_W'(SPEED_TGT_INIT);
  localparam logic [POWER_W-1:0] PWR_MAX   = POWER_W'(POWER_MAX);
  localparam logic [POWER_W-1:0] PWR_MIN   = POWER_W'(POWER_MIN);
  localparam logic [POWER_W-1:0] PWR_START = POWER_W'(POWER_START);

  logic [2:0]         state, state_nx;
  logic               working, working_nx;
  logic               dir, dir_nx;
  logic               stop_f, stop_nx;
  logic               rev_f, rev_nx;
  logic               inc_p, inc_nx;
  logic               dec_p, dec_nx;
  logic [SPEED_W-1:0] speed, speed_nx;
  logic [SPEED_W-1:0] tgt, tgt_nx;
  logic [POWER_W-1:0] power, power_nx;
  logic [SPEED_W-1:0] goal;
  logic               active, inv_go, stop_go;

`ifdef M3_REVERSE_DEADTIME_EN
  localparam int CNT_W = $clog2(DEAD_TICKS + 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TICKS - 1);
  logic [CNT_W-1:0] dead_cnt, dead_nx;
`endif

  // Reversal is only honoured once per ramp-down and never over a pending
  // stop; a start that loses to a reversal in the same cycle is dropped.
  assign active  = (state == S_RAMP_UP) || (state == S_RUN) || (state == S_RAMP_DOWN);
  assign inv_go  = invRotateI && active && !stop_f && !rev_f;
  assign stop_go = startI && active && !inv_go;
  assign goal    = (stop_f || rev_f) ? '0 : tgt;

  // State register and all registered outputs.
  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      state   <= S_IDLE;
      working <= 1'b0;
      dir     <= 1'b0;
      stop_f  <= 1'b0;
      rev_f   <= 1'b0;
      inc_p   <= 1'b0;
      dec_p   <= 1'b0;
      speed   <= '0;
      tgt     <= SPD_INIT;
      power   <= '0;
`ifdef M3_REVERSE_DEADTIME_EN
      dead_cnt <= '0;
`endif
    end else begin
      state   <= state_nx;
      working <= working_nx;
      dir     <= dir_nx;
      stop_f  <= stop_nx;
      rev_f   <= rev_nx;
      inc_p   <= inc_nx;
      dec_p   <= dec_nx;
      speed   <= speed_nx;
      tgt     <= tgt_nx;
      power   <= power_nx;
`ifdef M3_REVERSE_DEADTIME_EN
      dead_cnt <= dead_nx;
`endif
    end
  end

  // Speed target: saturating, adjustable in every state, conflicting pulses cancel.
  always_comb begin
    tgt_nx = tgt;
    if (speedINCi && !speedDECi && (tgt < SPD_MAX))
      tgt_nx = tgt + SPEED_W'(1);
    else if (speedDECi && !speedINCi && (tgt > SPD_MIN))
      tgt_nx = tgt - SPEED_W'(1);
  end

  // Next-state and datapath: power trim first, then FSM overrides.
  always_comb begin
    state_nx   = state;
    working_nx = working;
    dir_nx     = dir;
    stop_nx    = stop_f;
    rev_nx     = rev_f;
    speed_nx   = speed;
    inc_nx     = 1'b0;
    dec_nx     = 1'b0;
    power_nx   = power;
`ifdef M3_REVERSE_DEADTIME_EN
    dead_nx    = dead_cnt;
`endif
    if (working && powerINCi && !powerDECi && (power < PWR_MAX))
      power_nx = power + POWER_W'(1);
    else if (working && powerDECi && !powerINCi && (power > PWR_MIN))
      power_nx = power - POWER_W'(1);

    if (forceStopI) begin
      state_nx   = S_IDLE;
      working_nx = 1'b0;
      speed_nx   = '0;
      power_nx   = '0;
      stop_nx    = 1'b0;
      rev_nx     = 1'b0;
`ifdef M3_REVERSE_DEADTIME_EN
      dead_nx    = '0;
`endif
    end else if (inv_go) begin
      rev_nx   = 1'b1;
      state_nx = S_RAMP_DOWN;
    end else if (stop_go) begin
      stop_nx  = 1'b1;
      state_nx = S_RAMP_DOWN;
    end else begin
      case (state)
        S_IDLE: begin
          if (startI) begin
            state_nx   = S_RAMP_UP;
            working_nx = 1'b1;
            power_nx   = PWR_START;
            speed_nx   = '0;
          end
        end
        S_RAMP_UP: begin
          if (speed >= tgt) begin
            state_nx = S_RUN;
          end else if (tick100hzI) begin
            speed_nx = speed + SPEED_W'(1);
            inc_nx   = 1'b1;
          end
        end
        S_RUN: begin
          if (tgt > speed)      state_nx = S_RAMP_UP;
          else if (tgt < speed) state_nx = S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          if (speed <= goal) begin
            // goal is 0 whenever a flag is set, so here speed is 0 for the flag cases
            if (stop_f) begin
              state_nx   = S_IDLE;
              working_nx = 1'b0;
              power_nx   = '0;
              stop_nx    = 1'b0;
              rev_nx     = 1'b0;
            end else if (rev_f) begin
`ifdef M3_REVERSE_DEADTIME_EN
              state_nx = S_DEAD;
              dead_nx  = '0;
`else
              dir_nx   = ~dir;
              rev_nx   = 1'b0;
              state_nx = S_RAMP_UP;
`endif
            end else begin
              state_nx = S_RUN;
            end
          end else if (tick100hzI) begin
            speed_nx = speed - SPEED_W'(1);
            dec_nx   = 1'b1;
          end
        end
`ifdef M3_REVERSE_DEADTIME_EN
        S_DEAD: begin
          if (tick100hzI) begin
            if (dead_cnt == DEAD_LAST) begin
              dead_nx  = '0;
              dir_nx   = ~dir;
              rev_nx   = 1'b0;
              state_nx = S_RAMP_UP;
            end else begin
              dead_nx = dead_cnt + CNT_W'(1);
            end
          end
        end
`endif
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output mapping from registered state.
  always_comb begin
    stateO    = state;
    workingO  = working;
    dirO      = dir;
    speedLvlO = speed;
    speedTgtO = tgt;
    powerLvlO = power;
    speedINCo = inc_p;
    speedDECo = dec_p;
  end

endmodule

// File: tb/tb_m3_run_sequencer.sv
// Self-checking bench for m3_run_sequencer: reset checks, a vector table,
// directed multi-cycle sequences and a long randomized run compared every
// cycle against a behavioural reference model.
module tb_m3_run_sequencer;

  localparam int SPEED_MAX   = 15;
  localparam int POWER_MAX   = 15;
  localparam int POWER_MIN   = 1;
  localparam int POWER_START = 4;
  localparam int TGT_INIT    = 8;
  localparam int DEAD_TICKS  = 10;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_START = 7'b1000000;
  localparam logic [6:0] C_FORCE = 7'b0100000;
  localparam logic [6:0] C_INV   = 7'b0010000;
  localparam logic [6:0] C_SINC  = 7'b0001000;
  localparam logic [6:0] C_SDEC  = 7'b0000100;
  localparam logic [6:0] C_PINC  = 7'b0000010;
  localparam logic [6:0] C_PDEC  = 7'b0000001;

`ifdef M3_REVERSE_DEADTIME_EN
  localparam int EXP_DEAD_TICKS = DEAD_TICKS;
`else
  localparam int EXP_DEAD_TICKS = 0;
`endif

  logic       clkI = 1'b0;
  logic       rstI = 1'b1;
  logic       tick100hzI = 1'b0;
  logic       startI = 1'b0, forceStopI = 1'b0, invRotateI = 1'b0;
  logic       speedINCi = 1'b0, speedDECi = 1'b0, powerINCi = 1'b0, powerDECi = 1'b0;
  logic       workingO, dirO, speedINCo, speedDECo;
  logic [3:0] speedLvlO, speedTgtO, powerLvlO;
  logic [2:0] stateO;

  m3_run_sequencer dut (
    .clkI(clkI), .rstI(rstI), .tick100hzI(tick100hzI),
    .startI(startI), .forceStopI(forceStopI), .invRotateI(invRotateI),
    .speedINCi(speedINCi), .speedDECi(speedDECi),
    .powerINCi(powerINCi), .powerDECi(powerDECi),
    .workingO(workingO), .dirO(dirO), .speedLvlO(speedLvlO),
    .speedTgtO(speedTgtO), .powerLvlO(powerLvlO),
    .speedINCo(speedINCo), .speedDECo(speedDECo), .stateO(stateO)
  );

  always #5 clkI = ~clkI;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_inc = 0, n_dec = 0, n_dt = 0;

  // reference model (state codes as given for the stateO port)
  int m_state, m_spd, m_tgt, m_pwr, m_dead;
  bit m_work, m_dir, m_inc, m_dec, m_stop, m_rev;

  typedef struct {
    logic [6:0] cmd;
    int st;
    int tgt;
    int pwr;
    int wk;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_work = 0; m_dir = 0; m_spd = 0; m_tgt = TGT_INIT;
    m_pwr = 0; m_inc = 0; m_dec = 0; m_stop = 0; m_rev = 0; m_dead = 0;
  endtask

  task automatic model_step();
    int ot, goal;
    bit busy;
    if (rstI) begin
      model_reset();
      return;
    end
    ot = m_tgt;
    if (speedINCi && !speedDECi && m_tgt < SPEED_MAX) m_tgt++;
    if (speedDECi && !speedINCi && m_tgt > 1) m_tgt--;
    if (m_work && powerINCi && !powerDECi && m_pwr < POWER_MAX) m_pwr++;
    if (m_work && powerDECi && !powerINCi && m_pwr > POWER_MIN) m_pwr--;
    m_inc = 0;
    m_dec = 0;
    busy = (m_state >= 1) && (m_state <= 3);
    if (forceStopI) begin
      m_state = 0; m_work = 0; m_spd = 0; m_pwr = 0;
      m_stop = 0; m_rev = 0; m_dead = 0;
    end else if (invRotateI && busy && !m_stop && !m_rev) begin
      m_rev = 1; m_state = 3;
    end else if (startI && busy) begin
      m_stop = 1; m_state = 3;
    end else if (m_state == 0) begin
      if (startI) begin
        m_state = 1; m_work = 1; m_pwr = POWER_START; m_spd = 0;
      end
    end else if (m_state == 2) begin
      if (ot > m_spd) m_state = 1;
      else if (ot < m_spd) m_state = 3;
    end else if (m_state == 4) begin
      if (tick100hzI) begin
        m_dead++;
        if (m_dead == DEAD_TICKS) begin
          m_dead = 0; m_dir = !m_dir; m_rev = 0; m_state = 1;
        end
      end
    end else begin
      goal = (m_state == 3 && (m_stop || m_rev)) ? 0 : ot;
      if (m_state == 1 ? (m_spd >= goal) : (m_spd <= goal)) begin
        if (m_state == 1) m_state = 2;
        else if (m_stop) begin
          m_state = 0; m_work = 0; m_pwr = 0; m_stop = 0; m_rev = 0;
        end else if (m_rev) begin
`ifdef M3_REVERSE_DEADTIME_EN
          m_state = 4; m_dead = 0;
`else
          m_dir = !m_dir; m_rev = 0; m_state = 1;
`endif
        end else m_state = 2;
      end else if (tick100hzI) begin
        if (m_state == 1) begin m_spd++; m_inc = 1; end
        else begin m_spd--; m_dec = 1; end
      end
    end
  endtask

  task automatic check_model();
    chk("mdl_state", int'(stateO), m_state);
    chk("mdl_working", int'(workingO), int'(m_work));
    chk("mdl_dir", int'(dirO), int'(m_dir));
    chk("mdl_speed", int'(speedLvlO), m_spd);
    chk("mdl_target", int'(speedTgtO), m_tgt);
    chk("mdl_power", int'(powerLvlO), m_pwr);
    chk("mdl_inc", int'(speedINCo), int'(m_inc));
    chk("mdl_dec", int'(speedDECo), int'(m_dec));
    chk("inc_dec_exclusive", int'(speedINCo & speedDECo), 0);
  endtask

  task automatic cycle();
    if (tickI_in_dead()) n_dt++;
    @(posedge clkI);
    model_step();
    #1;
    check_model();
    if (speedINCo) n_inc++;
    if (speedDECo) n_dec++;
    cyc++;
  endtask

  function automatic bit tickI_in_dead();
    return tick100hzI && (stateO == 3'd4);
  endfunction

  function automatic bit dt();
    return (cyc % 10) == 9;
  endfunction

  function automatic bit rnd(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  task automatic step(input logic [6:0] c, input bit tk);
    {startI, forceStopI, invRotateI, speedINCi, speedDECi, powerINCi, powerDECi} = c;
    tick100hzI = tk;
    cycle();
    {startI, forceStopI, invRotateI, speedINCi, speedDECi, powerINCi, powerDECi} = '0;
    tick100hzI = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{C_PINC,          0, 8, 0, 0};
    vt[1] = '{C_SINC,          0, 9, 0, 0};
    vt[2] = '{C_SINC | C_SDEC, 0, 9, 0, 0};
    vt[3] = '{C_SDEC,          0, 8, 0, 0};
    vt[4] = '{C_START,         1, 8, 4, 1};
    vt[5] = '{C_PINC,          1, 8, 5, 1};
    vt[6] = '{C_PINC | C_PDEC, 1, 8, 5, 1};
    vt[7] = '{C_PDEC,          1, 8, 4, 1};
    vt[8] = '{C_FORCE | C_INV | C_START, 0, 8, 0, 0};
    vt[9] = '{C_PDEC,          0, 8, 0, 0};

    model_reset();
    rstI = 1'b1;
    step(C_NONE, 1'b0);
    step(C_START, 1'b1);
    chk("rst_state", int'(stateO), 0);
    chk("rst_working", int'(workingO), 0);
    chk("rst_dir", int'(dirO), 0);
    chk("rst_speed", int'(speedLvlO), 0);
    chk("rst_target", int'(speedTgtO), TGT_INIT);
    chk("rst_power", int'(powerLvlO), 0);
    chk("rst_pulses", int'({speedINCo, speedDECo}), 0);
    rstI = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].cmd, 1'b0);
      chk($sformatf("vec%0d_state", i), int'(stateO), vt[i].st);
      chk($sformatf("vec%0d_target", i), int'(speedTgtO), vt[i].tgt);
      chk($sformatf("vec%0d_power", i), int'(powerLvlO), vt[i].pwr);
      chk($sformatf("vec%0d_working", i), int'(workingO), vt[i].wk);
      chk($sformatf("vec%0d_dir", i), int'(dirO), 0);
      chk($sformatf("vec%0d_speed", i), int'(speedLvlO), 0);
    end

    // ramp up to default target
    n_inc = 0; n_dec = 0;
    step(C_START, dt());
    for (int k = 0; k < 300 && stateO != 3'd2; k++) step(C_NONE, dt());
    chk("rampup_state", int'(stateO), 2);
    chk("rampup_inc_pulses", n_inc, 8);
    chk("rampup_speed", int'(speedLvlO), 8);
    chk("rampup_power", int'(powerLvlO), 4);

    // lower target by 3
    n_dec = 0;
    for (int k = 0; k < 3; k++) step(C_SDEC, dt());
    for (int k = 0; k < 300 && !(stateO == 3'd2 && speedLvlO == 4'd5); k++) step(C_NONE, dt());
    chk("lower_target", int'(speedTgtO), 5);
    chk("lower_dec_pulses", n_dec, 3);
    chk("lower_state", int'(stateO), 2);
    chk("lower_speed", int'(speedLvlO), 5);

    // reversal through zero
    n_inc = 0; n_dec = 0; n_dt = 0;
    step(C_INV, dt());
    for (int k = 0; k < 800 && stateO != 3'd2; k++) step(C_NONE, dt());
    chk("rev_dec_pulses", n_dec, 5);
    chk("rev_inc_pulses", n_inc, 5);
    chk("rev_dir", int'(dirO), 1);
    chk("rev_speed", int'(speedLvlO), 5);
    chk("rev_dead_ticks", n_dt, EXP_DEAD_TICKS);

    // saturation
    for (int k = 0; k < 20; k++) step(C_PINC, dt());
    chk("power_sat_max", int'(powerLvlO), POWER_MAX);
    for (int k = 0; k < 20; k++) step(C_SDEC, dt());
    chk("target_sat_min", int'(speedTgtO), 1);
    step(C_FORCE, dt());
    chk("force_from_run_state", int'(stateO), 0);

    // force stop during ramp-up at speed 3
    n_dec = 0;
    step(C_START, dt());
    for (int k = 0; k < 7; k++) step(C_SINC, dt());
    for (int k = 0; k < 300 && !(stateO == 3'd1 && speedLvlO == 4'd3); k++) step(C_NONE, dt());
    chk("pre_force_speed", int'(speedLvlO), 3);
    step(C_FORCE, dt());
    chk("force_state", int'(stateO), 0);
    chk("force_working", int'(workingO), 0);
    chk("force_speed", int'(speedLvlO), 0);
    chk("force_power", int'(powerLvlO), 0);
    chk("force_dec_pulses", n_dec, 0);
    chk("force_dir_kept", int'(dirO), 1);
    chk("force_target_kept", int'(speedTgtO), 8);

    // randomized run against the model
    for (int i = 0; i < 20000; i++) begin
      rstI = rnd(3000);
      step({rnd(40), rnd(200), rnd(40), rnd(8), rnd(8), rnd(8), rnd(8)}, rnd(6));
      rstI = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m3_run_sequencer.md
Name: m3_run_sequencer

Overview:
- Run-control FSM for one 3-phase motor channel. Sits between the debounced front-panel command pulses and the m3 speed/power calculation path.
- Owns the run state, rotation direction, speed level and power level.
- Ramps speed one level per 100 Hz tick and issues single-cycle speedINC/speedDEC pulses so the downstream speed calculator tracks it.
- Handles graceful stop, force stop and direction reversal through zero speed.

Parameters:
SPEED_W, 4, width of speed level and target
POWER_W, 4, width of power level
SPEED_MAX, 15, upper saturation of speed target
POWER_MAX, 15, upper saturation of power level
POWER_MIN, 1, lower saturation of power level while working
POWER_START, 4, power level loaded on start
SPEED_TGT_INIT, 8, speed target after reset
DEAD_TICKS, 10, 100 Hz ticks held at zero speed before direction flip

Ports:
clkI  in  1  system clock
rstI  in  1  reset; asynchronous, active-high
tick100hzI  in  1  single-cycle 100 Hz strobe
startI  in  1  pulse: start when idle; graceful stop otherwise
forceStopI  in  1  level/pulse: immediate stop
invRotateI  in  1  pulse: reverse direction
speedINCi  in  1  pulse: speed target +1
speedDECi  in  1  pulse: speed target -1
powerINCi  in  1  pulse: power +1
powerDECi  in  1  pulse: power -1
workingO  out  1  motor energised
dirO  out  1  rotation direction, 0 = forward
speedLvlO  out  SPEED_W  current speed level
speedTgtO  out  SPEED_W  current speed target
powerLvlO  out  POWER_W  current power level
speedINCo  out  1  single-cycle pulse on each speed increment
speedDECo  out  1  single-cycle pulse on each speed decrement
stateO  out  3  FSM state code

Behaviour:
- Reset values:
  - state = IDLE; workingO, dirO, speedLvlO, powerLvlO, speedINCo, speedDECo = 0.
  - speedTgtO = SPEED_TGT_INIT; internal stop and reverse flags cleared; dead counter = 0.
- State codes: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, DEAD=4.
- All outputs are registered. A command takes effect on the clock edge that samples it.
- Command priority within one cycle: forceStopI > invRotateI > startI.
  - speedINCi with speedDECi in the same cycle: both ignored.
  - powerINCi with powerDECi in the same cycle: both ignored.
- forceStopI (any state): next cycle IDLE; workingO = speed = power = 0; flags cleared; dirO and target kept; no DEC pulses issued.
- Speed target:
  - Saturating in range 1..SPEED_MAX.
  - Adjustable in every state, including IDLE.
- Power level:
  - Saturating in range POWER_MIN..POWER_MAX.
  - Adjustable only while workingO = 1; forced to 0 in IDLE.
- IDLE: on startI -> RAMP_UP; workingO = 1; powerLvlO = POWER_START; speedLvlO = 0.
- RAMP_UP: on each tick, speed +1 with speedINCo high that cycle. When speed == target -> RUN. No step on the cycle of entry.
- RUN (re-evaluated every cycle):
  - target > speed -> RAMP_UP.
  - target < speed -> RAMP_DOWN.
- RAMP_DOWN:
  - On each tick, speed -1 with speedDECo high.
  - Exit when speed reaches the goal: 0 if the stop or reverse flag is set, else target.
  - Reached target with no flag set -> RUN.
  - Reached 0 with reverse flag set -> DEAD.
  - Reached 0 with stop flag set -> IDLE, workingO = 0, power = 0.
- startI in RAMP_UP/RUN/RAMP_DOWN: sets stop flag; -> RAMP_DOWN next cycle.
- invRotateI in RAMP_UP/RUN/RAMP_DOWN: sets reverse flag; -> RAMP_DOWN.
  - Ignored in IDLE and DEAD.
  - Ignored while the stop flag is set.
  - A second invRotateI while the reverse flag is set is ignored.
- DEAD:
  - Count ticks to DEAD_TICKS.
  - Then toggle dirO, clear reverse flag -> RAMP_UP toward current target.
- Tick arriving on the same cycle as a state change: the step is taken by the new state on the next tick, never twice.
- speedLvlO never wraps: no INC at target, no DEC at 0.
- At most one of speedINCo/speedDECo is high in any cycle.
- Reset asserted mid-operation: immediate return to reset values; no pulses.

Optional Feature:
M3_REVERSE_DEADTIME_EN
- Defined: DEAD state is used as described; reversal holds zero speed for DEAD_TICKS ticks.
- Undefined: DEAD state and its counter are not built. On reaching 0 with the reverse flag set, dirO toggles and the FSM goes directly to RAMP_UP in the same transition. stateO never reads 4.

Test Plan:
- Reset, startI with default target 8, ticks every 10 cycles -> RAMP_UP; exactly 8 speedINCo pulses, one per tick; then RUN, speedLvlO = 8, powerLvlO = 4.
- In RUN, 3x speedDECi -> target 5; RAMP_DOWN with 3 speedDECo pulses; then RUN at speed 5.
- RUN at speed 5, invRotateI -> 5 DEC pulses to 0; DEAD for 10 ticks; dirO toggles; 5 INC pulses; RUN. Without macro: no DEAD, toggle at 0.
- forceStopI in RAMP_UP at speed 3 -> next cycle IDLE, workingO = 0, speed = power = 0, no DEC pulses.
- Saturation: 20x powerINCi while running -> powerLvlO = 15. 20x speedDECi -> target = 1. powerINCi in IDLE -> powerLvlO stays 0.
- Simultaneous: forceStopI + invRotateI + startI in one cycle -> IDLE, dirO unchanged. speedINCi + speedDECi together -> target unchanged.
